// File: rtl/debounce_edge.sv
// Push-button conditioner: 2-flop synchronizer, stability-count FSM, registered level and edge pulses.
// Optional feature macro: DEBOUNCE_FALL_PULSE_EN (when undefined, fall_pulse is tied low).
module debounce_edge #(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             s1;
  logic             s2;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_nxt;
  logic             rise_nxt;
`ifdef DEBOUNCE_FALL_PULSE_EN
  logic             fall_nxt;
`endif

  // Stage boundary: asynchronous button into the clock domain
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  // Stage boundary: filter state, counter and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE_LOW;
      cnt        <= '0;
      level_out  <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      level_out  <= level_nxt;
      rise_pulse <= rise_nxt;
    end
  end

`ifdef DEBOUNCE_FALL_PULSE_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fall_pulse <= 1'b0;
    end else begin
      fall_pulse <= fall_nxt;
    end
  end
`else
  assign fall_pulse = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level_out;
    rise_nxt  = 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
    fall_nxt  = 1'b0;
`endif
    case (state)
      IDLE_LOW: begin
        level_nxt = 1'b0;
        if (s2) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s2) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          // Commit is reached at the compare value, so the counter never wraps
          state_nxt = IDLE_HIGH;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        level_nxt = 1'b1;
        if (!s2) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = '0;
        end
      end
      WAIT_LOW: begin
        if (s2) begin
          state_nxt = IDLE_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
          level_nxt = 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
          fall_nxt  = 1'b1;
`endif
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE_LOW;
        cnt_nxt   = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/debounce_edge.md
# debounce_edge

Upstream conditioning stage for the flip-flop/counter blocks. Takes a raw, asynchronous, bouncing push-button, synchronizes it into the `clock` domain and filters it with a stability counter. Drives a clean level plus single-cycle edge pulses. `rise_pulse` or `level_out` connects directly to the `D` input of the downstream D flip-flop or to a counter enable.

## Interface
- `STABLE_CYCLES`, 50000: consecutive synchronized samples that must agree before the level changes; minimum 2.
- `CNT_W`, 16: stability counter width; must hold `STABLE_CYCLES-1`.

- `clock`  in  1  single clock; all state on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `btn_in`  in  1  raw button, asynchronous to `clock`, may bounce.
- `level_out`  out  1  debounced level, registered.
- `rise_pulse`  out  1  one-cycle high on debounced 0→1, registered.
- `fall_pulse`  out  1  one-cycle high on debounced 1→0, registered; see Configuration.

## Operation
- Synchronizer: 2 flops, `s1 <= btn_in`, `s2 <= s1`. Only `s2` is used downstream.
- The FSM has 4 states:
  - `IDLE_LOW`: `level_out`=0. If `s2`=1, go to `WAIT_HIGH` and set cnt=0.
  - `WAIT_HIGH`:
    - If `s2`=0, abort to `IDLE_LOW` and set cnt=0 (glitch rejected, no pulse).
    - Else if cnt==`STABLE_CYCLES-1`, go to `IDLE_HIGH`, set `level_out`=1 and `rise_pulse`=1.
    - Else cnt+1.
  - `IDLE_HIGH`: `level_out`=1. If `s2`=0, go to `WAIT_LOW` and set cnt=0.
  - `WAIT_LOW`: mirror of `WAIT_HIGH`:
    - If `s2`=1, abort to `IDLE_HIGH`.
    - On commit, set `level_out`=0 and `fall_pulse`=1.
- Pulse outputs default to 0 every cycle and are high only in the cycle following a commit edge. Pulses never occur back-to-back, because a new commit needs at least `STABLE_CYCLES+1` further edges.
- The counter is unsigned, cleared on every state entry and never wraps: it saturates at the compare value because the commit happens there.
- Any single `s2` sample that matches the current level during a WAIT state restarts filtering from zero.

## Timing
- Reset (async assert, sync release effect) sets:
  - `s1`=`s2`=0, state `IDLE_LOW`, cnt=0.
  - `level_out`=0, `rise_pulse`=0, `fall_pulse`=0.
  - The effect is immediate on assertion, independent of `clock`.
- Latency, with edge 0 = first posedge where `s1` captures the new value and the value held:
  - Edge 1: `s2` updates.
  - Edge 2: enter WAIT, cnt=0.
  - Edge j: cnt=j-2.
  - Edge `STABLE_CYCLES+2`: commit. `level_out` changes and the pulse is high until edge `STABLE_CYCLES+3`.
- With `STABLE_CYCLES`=4: commit at edge 6.
- Reset mid-WAIT: the partial count is discarded and no pulse is emitted.
  - If `btn_in` is still high after release, it is treated as a fresh press: commit `STABLE_CYCLES+2` edges after the first post-release sampling edge.
- Button held high through reset release produces a `rise_pulse` (intentional; the downstream block sees a press).

## Configuration
- `DEBOUNCE_FALL_PULSE_EN`:
  - Defined: `fall_pulse` is generated as described.
  - Undefined: `fall_pulse` is tied constant 0 and its register is removed. `level_out` and `WAIT_LOW` behaviour are unchanged.

## Test plan
All tests use `STABLE_CYCLES`=4.
- Reset, then `btn_in`=1 held → `level_out` 0→1 and `rise_pulse`=1 for exactly one cycle, both at edge 6 after first sampling. `fall_pulse` stays 0.
- `btn_in` high for 3 edges then low → `level_out` stays 0; `rise_pulse` never asserts.
- Bounce 1,0,1,0,1 (one edge each), then held high → exactly one `rise_pulse`, at edge 6 after the last 0→1 sample.
- From debounced high, `btn_in`=0 held → `level_out` 1→0 at edge 6. With macro: `fall_pulse`=1 for one cycle. Without macro: `fall_pulse`=0 throughout.
- Assert `reset` asynchronously in `WAIT_HIGH` (cnt=2) → all outputs 0 immediately.
  - Release with `btn_in`=0 → no pulse.
  - Release with `btn_in`=1 → `rise_pulse` at edge 6 after release.
- Debounced high, then a 3-edge low glitch → `level_out` stays 1; no `fall_pulse`.
